ysyx_2022040010_axi_master: RTL and testbench
=============================================

// Module: ysyx_2022040010_axi_master
// PURPOSE
//   AXI4 master bridge directly downstream of the cache/uncache arbiter. Takes the arbiter's flat
//   read request (ar_e/id/addr) and write request (aw_e/addr/data/mask) and runs single-beat AXI4
//   transactions on the memory bus. Returns read data, read ID and one-cycle completion pulses.
//   Read and write channels are independent FSMs and may be in flight at the same time.
// PARAMETERS
//   ID_W    4   AXI ID width (arbiter IDs: 0 icache, 1 dcache, 2 uncache)
//   ADDR_W  32  address width
//   DATA_W  64  data width; STRB_W = DATA_W/8
// PORTS
//   clk          in   1       clock, all state updates on rising edge
//   rst          in   1       asynchronous, active-low reset
//   ar_e_i       in   1       read request from arbiter (level, held until r_refresh_o)
//   ar_id_i      in   ID_W    requester ID
//   ar_addr_i    in   ADDR_W  read address
//   r_data_o     out  DATA_W  read data, valid while r_refresh_o=1
//   r_id_o       out  ID_W    ID of completed read
//   r_err_o      out  1       rresp!=OKAY on completed read, valid with r_refresh_o
//   r_refresh_o  out  1       1-cycle read-done pulse
//   aw_e_i       in   1       write request (level, held until w_refresh_o)
//   aw_addr_i    in   ADDR_W  write address
//   w_data_i     in   DATA_W  write data
//   w_mask_i     in   STRB_W  byte strobes
//   w_err_o      out  1       bresp!=OKAY, valid with w_refresh_o
//   w_refresh_o  out  1       1-cycle write-done pulse
//   axi_ar{valid,ready,addr,id,len,size,burst}  AR channel (ready in, rest out)
//   axi_r{valid,ready,data,id,resp,last}        R channel (ready out, rest in)
//   axi_aw{valid,ready,addr,id,len,size,burst}  AW channel (ready in, rest out)
//   axi_w{valid,ready,data,strb,last}           W channel (ready in, rest out)
//   axi_b{valid,ready,id,resp}                  B channel (ready out, rest in)
// BEHAVIOUR
//   - Reset (rst=0, async): both FSMs to IDLE; every valid/ready/refresh/err output 0; all
//     registered address/data/ID outputs 0. Takes effect mid-transaction; no AXI cleanup.
//   - Constants: arlen=awlen=0, arsize=awsize=3'b011, arburst=awburst=2'b01, wlast=1, awid=0.
//   - Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_DONE -> R_IDLE.
//     R_IDLE: if ar_e_i, latch id/addr into axi_araddr/arid, arvalid<=1, go R_ADDR.
//     R_ADDR: hold arvalid/addr stable; on arvalid&arready: arvalid<=0, rready<=1, go R_DATA.
//     R_DATA: on rvalid&rready: latch rdata->r_data_o, rid->r_id_o, |rresp->r_err_o;
//       rready<=0; go R_DONE. rlast ignored (len=0); rid mismatch not checked.
//     R_DONE: r_refresh_o=1 for exactly this cycle; go R_IDLE. r_data_o holds until next read.
//   - Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_DONE -> W_IDLE.
//     W_IDLE: if aw_e_i, latch addr/data/mask, awvalid<=1 and wvalid<=1 same cycle, go W_REQ.
//     W_REQ: AW and W handshakes independent; each valid drops the cycle after its own handshake;
//       both may complete in the same cycle or in either order. When both done: bready<=1, W_RESP.
//     W_RESP: on bvalid&bready: bready<=0, w_err_o<=|bresp, go W_DONE.
//     W_DONE: w_refresh_o=1 one cycle; go W_IDLE.
//   - Min latency, slave ready/valid in first possible cycle: request seen in IDLE at edge T,
//     arvalid high T+1, refresh pulse at T+3 (read) / T+3 (write).
//   - Requests sampled only in IDLE; input changes while busy ignored. Requester must drop
//     ar_e_i/aw_e_i the cycle after refresh, else a second transaction issues (legal, by design).
//   - Read and write simultaneous: both FSMs proceed in parallel; no ordering enforced between
//     them (arbiter/cache guarantee no same-address RAW hazard in flight).
//   - Valid never deasserted before handshake; payload stable while valid=1 (AXI rule).
// TESTING
//   1. Read, slave arready/rvalid immediate, addr=0x8000_0000 id=1 rdata=0xDEAD_BEEF_0123_4567
//      -> arvalid 1 cycle, r_refresh_o pulse 3 cycles after request, r_id_o=1, data matches.
//   2. Write, awready delayed 3 cycles, wready immediate, mask=0x0F -> wvalid drops after 1 cycle,
//      awvalid held 4 cycles with stable addr, bready only after both, single w_refresh_o pulse.
//   3. Concurrent read (id=0) and write to 0x8000_1000 -> both complete, one pulse each, no stall.
//   4. rresp=2'b10 / bresp=2'b11 -> r_err_o / w_err_o =1 with their refresh pulse, 0 otherwise.
//   5. rst low mid R_DATA with rvalid pending -> all outputs 0 immediately; after release FSM in
//      IDLE, new read completes normally.
//   6. ar_e_i held high 10 cycles with random slave backpressure -> back-to-back reads, each
//      completion one pulse, arvalid never drops before arready.

Source files
------------

// File: rtl/ysyx_2022040010_axi_if.sv
// AXI4 bus bundle between the bridge (master) and the memory side (slave).
// Single-beat use only: len/size/burst are still carried so the bus stays AXI4-shaped.
interface ysyx_2022040010_axi_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rid, rresp, rlast, output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rid, rresp, rlast, input rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready
  );
endinterface

// File: rtl/ysyx_2022040010_axi_master.sv
// Arbiter-to-AXI4 bridge: single-beat reads and writes, each driven by its own FSM
// so a read and a write can be in flight together.
module ysyx_2022040010_axi_master #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_e_i,
  input  logic [ID_W-1:0]   ar_id_i,
  input  logic [ADDR_W-1:0] ar_addr_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic [ID_W-1:0]   r_id_o,
  output logic              r_err_o,
  output logic              r_refresh_o,
  input  logic              aw_e_i,
  input  logic [ADDR_W-1:0] aw_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic [STRB_W-1:0] w_mask_i,
  output logic              w_err_o,
  output logic              w_refresh_o,
  ysyx_2022040010_axi_if.master axi
);
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2, R_DONE = 2'd3;
  localparam logic [1:0] W_IDLE = 2'd0, W_REQ  = 2'd1, W_RESP = 2'd2, W_DONE = 2'd3;

  logic [1:0]        r_rstate;
  logic              r_arvalid, r_rready, r_rerr;
  logic [ADDR_W-1:0] r_araddr;
  logic [ID_W-1:0]   r_arid, r_rid;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        r_wstate;
  logic              r_awvalid, r_wvalid, r_bready, r_werr;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;

  logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
  logic w_unused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rerr    <= 1'b0;
      r_araddr  <= '0;
      r_arid    <= '0;
      r_rid     <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (ar_e_i) begin
          r_araddr  <= ar_addr_i;
          r_arid    <= ar_id_i;
          r_arvalid <= 1'b1;
          r_rstate  <= R_ADDR;
        end
        R_ADDR: if (axi.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_rstate  <= R_DATA;
        end
        // single beat: rlast and rid/arid agreement are not checked
        R_DATA: if (axi.rvalid) begin
          r_rdata  <= axi.rdata;
          r_rid    <= axi.rid;
          r_rerr   <= |axi.rresp;
          r_rready <= 1'b0;
          r_rstate <= R_DONE;
        end
        default: begin
          r_rerr   <= 1'b0;
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  // A side is finished once its valid is low in W_REQ, or it handshakes this cycle.
  assign w_aw_hs  = r_awvalid & axi.awready;
  assign w_w_hs   = r_wvalid & axi.wready;
  assign w_aw_fin = ~r_awvalid | w_aw_hs;
  assign w_w_fin  = ~r_wvalid | w_w_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_werr    <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (aw_e_i) begin
          r_awaddr  <= aw_addr_i;
          r_wdata   <= w_data_i;
          r_wstrb   <= w_mask_i;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_wstate  <= W_REQ;
        end
        W_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (axi.bvalid) begin
          r_bready <= 1'b0;
          r_werr   <= |axi.bresp;
          r_wstate <= W_DONE;
        end
        default: begin
          r_werr   <= 1'b0;
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  assign axi.arvalid = r_arvalid;
  assign axi.araddr  = r_araddr;
  assign axi.arid    = r_arid;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b011;
  assign axi.arburst = 2'b01;
  assign axi.rready  = r_rready;

  assign axi.awvalid = r_awvalid;
  assign axi.awaddr  = r_awaddr;
  assign axi.awid    = '0;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b011;
  assign axi.awburst = 2'b01;
  assign axi.wvalid  = r_wvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = r_bready;

  assign r_data_o    = r_rdata;
  assign r_id_o      = r_rid;
  assign r_err_o     = r_rerr;
  assign r_refresh_o = (r_rstate == R_DONE);
  assign w_err_o     = r_werr;
  assign w_refresh_o = (r_wstate == W_DONE);

  assign w_unused = ^{axi.rlast, axi.bid};
endmodule

// File: tb/tb_ysyx_2022040010_axi_master.sv
// Directed bench: behavioural AXI slave with per-channel delays, scoreboard queues
// filled by stimulus, and a negedge monitor that checks completions and bus rules.
module tb_ysyx_2022040010_axi_master;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, STRB_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              ar_e, r_err, r_ref, aw_e, w_err, w_ref;
  logic [ID_W-1:0]   ar_id, r_id;
  logic [ADDR_W-1:0] ar_addr, aw_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic [STRB_W-1:0] w_mask;

  ysyx_2022040010_axi_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi();

  ysyx_2022040010_axi_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst_n),
    .ar_e_i(ar_e), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .r_data_o(r_data), .r_id_o(r_id), .r_err_o(r_err), .r_refresh_o(r_ref),
    .aw_e_i(aw_e), .aw_addr_i(aw_addr), .w_data_i(w_data), .w_mask_i(w_mask),
    .w_err_o(w_err), .w_refresh_o(w_ref),
    .axi(axi)
  );

  typedef struct packed {logic [31:0] addr; logic [3:0] id; logic [63:0] data; logic err;} rd_t;
  typedef struct packed {logic [31:0] addr; logic [63:0] data; logic [7:0] strb; logic err;} wr_t;
  typedef struct packed {logic [63:0] data; logic [1:0] resp;} rsp_t;

  rd_t         exp_r[$];
  wr_t         exp_w[$];
  rsp_t        rsp_q[$];
  logic [1:0]  bresp_q[$];
  logic [35:0] arcap[$];
  logic [3:0]  rid_q[$];
  logic [31:0] awcap[$];
  logic [71:0] wcap[$];

  int total = 0, bad = 0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit rnd = 1'b0;
  int ar_len_last = -1, aw_len_last = -1, w_len_last = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int d);
    return rnd ? int'($urandom_range(0, 2)) : d;
  endfunction

  // ---------------- slave ----------------
  initial begin
    axi.arready = 1'b0;
    forever begin
      tick();
      if (rst_n && axi.arvalid) begin
        repeat (pick(ar_dly)) tick();
        axi.arready = 1'b1;
        arcap.push_back({axi.araddr, axi.arid});
        rid_q.push_back(axi.arid);
        tick();
        axi.arready = 1'b0;
      end
    end
  end

  rsp_t s_r;
  initial begin
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rid = '0; axi.rresp = '0; axi.rlast = 1'b1;
    forever begin
      tick();
      if (rst_n && axi.rready && rid_q.size() > 0) begin
        repeat (pick(r_dly)) tick();
        s_r = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
        axi.rid    = rid_q.pop_front();
        axi.rdata  = s_r.data;
        axi.rresp  = s_r.resp;
        axi.rvalid = 1'b1;
        tick();
        axi.rvalid = 1'b0;
      end
    end
  end

  initial begin
    axi.awready = 1'b0;
    forever begin
      tick();
      if (rst_n && axi.awvalid) begin
        repeat (pick(aw_dly)) tick();
        axi.awready = 1'b1;
        awcap.push_back(axi.awaddr);
        tick();
        axi.awready = 1'b0;
      end
    end
  end

  initial begin
    axi.wready = 1'b0;
    forever begin
      tick();
      if (rst_n && axi.wvalid) begin
        repeat (pick(w_dly)) tick();
        axi.wready = 1'b1;
        wcap.push_back({axi.wdata, axi.wstrb});
        tick();
        axi.wready = 1'b0;
      end
    end
  end

  initial begin
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    forever begin
      tick();
      if (rst_n && axi.bready) begin
        repeat (pick(b_dly)) tick();
        axi.bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        p_rref, p_wref, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_br, aw_hs, w_hs;
  logic [31:0] p_araddr, p_awaddr;
  logic [71:0] p_wpay;
  int          ar_cnt, aw_cnt, w_cnt;
  rd_t         m_r;
  wr_t         m_w;
  logic [35:0] m_ac;
  logic [31:0] m_aw;
  logic [71:0] m_wd;

  initial begin
    {p_rref, p_wref, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_br, aw_hs, w_hs} = '0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {p_rref, p_wref, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_br, aw_hs, w_hs} = '0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (r_ref) begin
        chk("r_pulse_single", {p_rref, r_ref}, 2'b01);
        chk("r_expected", (exp_r.size() > 0 && arcap.size() > 0), 1);
        if (exp_r.size() > 0 && arcap.size() > 0) begin
          m_r  = exp_r.pop_front();
          m_ac = arcap.pop_front();
          chk("araddr", m_ac[35:4], m_r.addr);
          chk("arid", m_ac[3:0], m_r.id);
          chk("r_id", r_id, m_r.id);
          chk("r_data", r_data, m_r.data);
          chk("r_err", r_err, m_r.err);
        end
      end else if (p_rref) chk("r_err_after", r_err, 0);
      if (w_ref) begin
        chk("w_pulse_single", {p_wref, w_ref}, 2'b01);
        chk("w_expected", (exp_w.size() > 0 && awcap.size() > 0 && wcap.size() > 0), 1);
        if (exp_w.size() > 0 && awcap.size() > 0 && wcap.size() > 0) begin
          m_w  = exp_w.pop_front();
          m_aw = awcap.pop_front();
          m_wd = wcap.pop_front();
          chk("awaddr", m_aw, m_w.addr);
          chk("wdata", m_wd[71:8], m_w.data);
          chk("wstrb", m_wd[7:0], m_w.strb);
          chk("w_err", w_err, m_w.err);
        end
      end else if (p_wref) chk("w_err_after", w_err, 0);
      // valid must hold with stable payload until its handshake
      if (p_arv && !p_arr) begin
        chk("arvalid_hold", axi.arvalid, 1);
        chk("araddr_stable", axi.araddr, p_araddr);
      end
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", axi.awvalid, 1);
        chk("awaddr_stable", axi.awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        chk("wvalid_hold", axi.wvalid, 1);
        chk("wdata_stable", {axi.wdata, axi.wstrb}, p_wpay);
      end
      if (p_awv && p_awr) aw_hs = 1'b1;
      if (p_wv && p_wr) w_hs = 1'b1;
      if (axi.bready && !p_br) begin
        chk("bready_after_aw", aw_hs, 1);
        chk("bready_after_w", w_hs, 1);
        aw_hs = 1'b0;
        w_hs  = 1'b0;
      end
      if (axi.arvalid) ar_cnt++; else if (ar_cnt > 0) begin ar_len_last = ar_cnt; ar_cnt = 0; end
      if (axi.awvalid) aw_cnt++; else if (aw_cnt > 0) begin aw_len_last = aw_cnt; aw_cnt = 0; end
      if (axi.wvalid) w_cnt++; else if (w_cnt > 0) begin w_len_last = w_cnt; w_cnt = 0; end
      p_rref = r_ref; p_wref = w_ref;
      p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
      p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
      p_wv = axi.wvalid; p_wr = axi.wready; p_wpay = {axi.wdata, axi.wstrb};
      p_br = axi.bready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_rd(input logic [31:0] a, input logic [3:0] id, input logic [63:0] d,
                         input logic [1:0] resp);
    exp_r.push_back({a, id, d, |resp});
    rsp_q.push_back({d, resp});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                         input logic [1:0] resp);
    exp_w.push_back({a, d, m, |resp});
    bresp_q.push_back(resp);
  endtask

  task automatic issue_rd(input logic [31:0] a, input logic [3:0] id);
    ar_addr = a; ar_id = id; ar_e = 1'b1;
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    aw_addr = a; w_data = d; w_mask = m; aw_e = 1'b1;
  endtask

  task automatic wait_rd(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!r_ref && lat < 50);
    ar_e = 1'b0;
    chk("rd_done", r_ref, 1);
  endtask

  task automatic wait_wr(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!w_ref && lat < 50);
    aw_e = 1'b0;
    chk("wr_done", w_ref, 1);
  endtask

  task automatic wait_both(output int rl, output int wl);
    rl = 0; wl = 0;
    for (int c = 1; c <= 50 && (rl == 0 || wl == 0); c++) begin
      tick();
      if (r_ref && rl == 0) begin rl = c; ar_e = 1'b0; end
      if (w_ref && wl == 0) begin wl = c; aw_e = 1'b0; end
    end
    ar_e = 1'b0; aw_e = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
    chk({tag, "_rready"}, axi.rready, 0);
    chk({tag, "_awvalid"}, axi.awvalid, 0);
    chk({tag, "_wvalid"}, axi.wvalid, 0);
    chk({tag, "_bready"}, axi.bready, 0);
    chk({tag, "_refresh"}, {r_ref, w_ref}, 0);
    chk({tag, "_err"}, {r_err, w_err}, 0);
    chk({tag, "_araddr_id"}, {axi.araddr, axi.arid}, 0);
    chk({tag, "_awaddr"}, axi.awaddr, 0);
    chk({tag, "_wdata"}, {axi.wdata, axi.wstrb}, 0);
    chk({tag, "_rdata"}, r_data, 0);
    chk({tag, "_rid"}, r_id, 0);
  endtask

  // ---------------- directed tests ----------------
  int rl, wl, n;

  initial begin
    rst_n = 1'b0; ar_e = 1'b0; ar_id = '0; ar_addr = '0;
    aw_e = 1'b0; aw_addr = '0; w_data = '0; w_mask = '0;
    repeat (3) tick();
    chk_zero("rst");
    chk("ar_const", {axi.arlen, axi.arsize, axi.arburst}, {8'd0, 3'b011, 2'b01});
    chk("aw_const", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.wlast},
        {4'd0, 8'd0, 3'b011, 2'b01, 1'b1});
    rst_n = 1'b1;
    tick();

    // 1: immediate read
    push_rd(32'h8000_0000, 4'd1, 64'hDEAD_BEEF_0123_4567, 2'b00);
    issue_rd(32'h8000_0000, 4'd1);
    wait_rd(rl);
    chk("t1_latency", rl, 3);
    tick(); tick();
    chk("t1_arvalid_cycles", ar_len_last, 1);

    // 2: awready delayed 3 cycles, wready immediate
    aw_dly = 3;
    push_wr(32'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F, 2'b00);
    issue_wr(32'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F);
    wait_wr(wl);
    chk("t2_latency", wl, 6);
    tick(); tick();
    chk("t2_awvalid_cycles", aw_len_last, 4);
    chk("t2_wvalid_cycles", w_len_last, 1);
    aw_dly = 0;

    // 3: concurrent read and write
    push_rd(32'h8000_2000, 4'd0, 64'h0BAD_F00D_CAFE_0000, 2'b00);
    push_wr(32'h8000_1000, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 2'b00);
    issue_rd(32'h8000_2000, 4'd0);
    issue_wr(32'h8000_1000, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    wait_both(rl, wl);
    chk("t3_rd_latency", rl, 3);
    chk("t3_wr_latency", wl, 3);
    tick(); tick();

    // 4: error responses, then a clean read
    push_rd(32'h1000_0000, 4'd2, 64'h0000_0000_0000_0055, 2'b10);
    push_wr(32'h1000_0008, 64'h0000_0000_0000_00AA, 8'hF0, 2'b11);
    issue_rd(32'h1000_0000, 4'd2);
    issue_wr(32'h1000_0008, 64'h0000_0000_0000_00AA, 8'hF0);
    wait_both(rl, wl);
    chk("t4_both_done", (rl > 0) && (wl > 0), 1);
    tick();
    push_rd(32'h8000_0010, 4'd1, 64'h0123_4567_89AB_CDEF, 2'b00);
    issue_rd(32'h8000_0010, 4'd1);
    wait_rd(rl);
    tick(); tick();

    // 5: reset while waiting for rvalid
    r_dly = 6;
    push_rd(32'h8000_0040, 4'd1, 64'h0BAD_0BAD_0BAD_0BAD, 2'b00);
    issue_rd(32'h8000_0040, 4'd1);
    n = 0;
    do begin tick(); n++; end while (!axi.rready && n < 20);
    ar_e = 1'b0;
    chk("t5_in_rdata", axi.rready, 1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    repeat (10) tick();
    exp_r.delete(); rsp_q.delete(); arcap.delete(); rid_q.delete();
    r_dly = 0;
    rst_n = 1'b1;
    tick();
    push_rd(32'h8000_0080, 4'd2, 64'hFEED_FACE_1234_5678, 2'b00);
    issue_rd(32'h8000_0080, 4'd2);
    wait_rd(rl);
    chk("t5_latency", rl, 3);
    tick(); tick();

    // 6: request held high, random slave backpressure, back-to-back reads
    rnd = 1'b1;
    push_rd(32'h8000_0100, 4'd1, 64'h1111_1111_1111_1111, 2'b00);
    push_rd(32'h8000_0100, 4'd1, 64'h2222_2222_2222_2222, 2'b00);
    push_rd(32'h8000_0100, 4'd1, 64'h3333_3333_3333_3333, 2'b00);
    issue_rd(32'h8000_0100, 4'd1);
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      tick();
      if (r_ref) n++;
    end
    ar_e = 1'b0;
    rnd = 1'b0;
    chk("t6_completions", n, 3);
    repeat (8) tick();

    chk("scoreboard_drained", exp_r.size() + exp_w.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
